// File: rtl/pixel_plot_queue_if.sv
// Plot request and frame-buffer write signals of pixel_plot_queue.
// The master side is the curve generator plus the frame buffer; the slave
// side is the queue itself.
interface pixel_plot_queue_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_px;
    logic signed [15:0] in_py;
    logic [7:0]         in_colour;
    logic               wr_allow;
    logic               wr_en;
    logic [18:0]        wr_addr;
    logic [7:0]         wr_data;

    modport master (
        output in_valid, in_px, in_py, in_colour, wr_allow,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_px, in_py, in_colour, wr_allow,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pixel_plot_queue.sv
// Pixel plot queue: clips plot requests to the visible window, turns them
// into linear frame-buffer addresses, buffers them and writes them out when
// the frame buffer allows. A clear command sweeps the whole buffer with 0x00.
module pixel_plot_queue #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_plot_queue_if.slave    bus,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic [15:0]          clip_count
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int X_MIN = -(H_VISIBLE / 2);
    localparam int X_MAX = H_VISIBLE / 2 - 1;
    localparam int Y_MIN = -(V_VISIBLE / 2);
    localparam int Y_MAX = V_VISIBLE / 2 - 1;
    // Address of the screen centre (0,0): origin sits mid-screen.
    localparam int BASE  = (H_VISIBLE * V_VISIBLE + H_VISIBLE) / 2;
    localparam logic [18:0] LAST_ADDR = 19'(H_VISIBLE * V_VISIBLE - 1);

    typedef enum logic [0:0] {RUN, CLEAR} state_t;

    state_t             state_q, state_d;

    // Address stage: one registered visible point waiting for its address.
    logic               stage_valid;
    logic signed [15:0] stage_px, stage_py;
    logic [7:0]         stage_colour;
    logic [18:0]        stage_addr;

    // FIFO of {addr, colour}; sized DEPTH so the stage can always push.
    logic [26:0]        fifo_mem [DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      occupancy;

    logic [18:0]        clear_ptr;

    logic               transfer, visible;
    logic               accept, push, pop, flush, clear_wr;

    assign occupancy  = fifo_count + CW'(stage_valid);
    // Ready depends only on registered state; reset holds it low.
    assign bus.in_ready = reset && (state_q == RUN) && (occupancy < CW'(DEPTH));
    assign transfer   = bus.in_valid && bus.in_ready;
    assign visible    = (int'(bus.in_px) >= X_MIN) && (int'(bus.in_px) <= X_MAX) &&
                        (int'(bus.in_py) >= Y_MIN) && (int'(bus.in_py) <= Y_MAX);
    assign stage_addr = 19'(BASE + int'(stage_py) * H_VISIBLE + int'(stage_px));
    assign clear_busy = (state_q == CLEAR);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next state and per-edge control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        accept   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        clear_wr = 1'b0;
        case (state_q)
            RUN: begin
                if (clear_start) begin
                    // Clear wins over any same-edge transfer or write.
                    state_d = CLEAR;
                    flush   = 1'b1;
                end else begin
                    accept = transfer;
                    push   = stage_valid;
                    pop    = (fifo_count != '0) && bus.wr_allow;
                end
            end
            CLEAR: begin
                clear_wr = bus.wr_allow;
                if (bus.wr_allow && (clear_ptr == LAST_ADDR)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Address stage: capture visible points; clipped ones are dropped here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid  <= 1'b0;
            stage_px     <= '0;
            stage_py     <= '0;
            stage_colour <= '0;
        end else begin
            stage_valid <= accept && visible;
            if (accept) begin
                stage_px     <= bus.in_px;
                stage_py     <= bus.in_py;
                stage_colour <= bus.in_colour;
            end
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the empty count guards stale entries.
        if (push) fifo_mem[wr_ptr] <= {stage_addr, stage_colour};
    end

    // Frame-buffer write port: queue pop or clear sweep, one cycle per write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else if (pop) begin
            bus.wr_en                  <= 1'b1;
            {bus.wr_addr, bus.wr_data} <= fifo_mem[rd_ptr];
        end else if (clear_wr) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= clear_ptr;
            bus.wr_data <= 8'h00;
        end else begin
            bus.wr_en <= 1'b0;
        end
    end

    // Clear sweep pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        clear_ptr <= '0;
        else if (flush)    clear_ptr <= '0;
        else if (clear_wr) clear_ptr <= clear_ptr + 19'd1;
    end

    // Saturating count of clipped requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      clip_count <= '0;
        else if (flush)  clip_count <= '0;
        else if (accept && !visible && (clip_count != 16'hFFFF))
            clip_count <= clip_count + 16'd1;
    end

endmodule

// File: tb/tb_pixel_plot_queue.sv
// Directed bench for pixel_plot_queue: a full-size instance for the plotting,
// back-pressure and mid-clear reset scenarios, and a small-screen instance
// whose complete clear sweep fits in a short run.
module tb_pixel_plot_queue;

    logic clk = 1'b0;
    logic reset, reset_s;
    logic clear_start, clear_start_s;
    logic clear_busy, clear_busy_s;
    logic [15:0] clip_count, clip_count_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge = 0;

    typedef struct { logic [18:0] addr; logic [7:0] data; int cyc; } wr_t;
    wr_t wlog[$];
    wr_t slog[$];

    pixel_plot_queue_if bus ();
    pixel_plot_queue_if bus_s ();

    pixel_plot_queue dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clip_count  (clip_count)
    );

    pixel_plot_queue #(.H_VISIBLE(32), .V_VISIBLE(16), .DEPTH(8)) dut_s (
        .clk         (clk),
        .reset       (reset_s),
        .bus         (bus_s),
        .clear_start (clear_start_s),
        .clear_busy  (clear_busy_s),
        .clip_count  (clip_count_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write loggers, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.wr_en === 1'b1)   wlog.push_back('{bus.wr_addr, bus.wr_data, cyc});
        if (bus_s.wr_en === 1'b1) slog.push_back('{bus_s.wr_addr, bus_s.wr_data, cyc});
    end

    function automatic logic [18:0] exp_addr(input int px, input int py);
        return 19'(153920 + py * 640 + px);
    endfunction

    // Offer one point on the full-size instance; called at a falling edge.
    task automatic send(input int px, input int py, input logic [7:0] c);
        int waited = 0;
        bus.in_valid  = 1'b1;
        bus.in_px     = 16'(px);
        bus.in_py     = 16'(py);
        bus.in_colour = c;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready got %b want 1", bus.in_ready);
        end
        last_edge = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 28'd0) begin
            errors++;
            $display("FAIL reset_wr got en=%b addr=%0d data=%0h want 0/0/0",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        checks++;
        if (clear_busy !== 1'b0 || clip_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_status got busy=%b clip=%0d want 0/0", clear_busy, clip_count);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        reset   = 1'b1;
        reset_s = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL release got ready=%b wr_en=%b want 1/0", bus.in_ready, bus.wr_en);
        end
    endtask

    task automatic test_single();
        bus.wr_allow = 1'b1;
        wlog.delete();
        send(0, 0, 8'h5A);
        repeat (6) @(negedge clk);
        checks++;
        if (wlog.size() != 1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", wlog.size());
        end else begin
            checks++;
            if (wlog[0].addr !== 19'd153920 || wlog[0].data !== 8'h5A) begin
                errors++;
                $display("FAIL single_data got %0d/%0h want 153920/5a", wlog[0].addr, wlog[0].data);
            end
            checks++;
            if (wlog[0].cyc != last_edge + 2) begin
                errors++;
                $display("FAIL single_latency got edge %0d want %0d", wlog[0].cyc, last_edge + 2);
            end
        end
    endtask

    task automatic test_clip();
        wlog.delete();
        send(-320, -240, 8'h01);
        send(319, 239, 8'h02);
        send(320, 0, 8'h03);
        send(0, -241, 8'h04);
        repeat (6) @(negedge clk);
        checks++;
        if (wlog.size() != 2) begin
            errors++;
            $display("FAIL clip_writes got %0d want 2", wlog.size());
        end else begin
            checks++;
            if (wlog[0].addr !== 19'd0 || wlog[0].data !== 8'h01) begin
                errors++;
                $display("FAIL clip_corner_lo got %0d/%0h want 0/01", wlog[0].addr, wlog[0].data);
            end
            checks++;
            if (wlog[1].addr !== 19'd307199 || wlog[1].data !== 8'h02) begin
                errors++;
                $display("FAIL clip_corner_hi got %0d/%0h want 307199/02", wlog[1].addr, wlog[1].data);
            end
        end
        checks++;
        if (clip_count !== 16'd2) begin
            errors++;
            $display("FAIL clip_count got %0d want 2", clip_count);
        end
    endtask

    task automatic test_back_pressure();
        int acc = 0;
        logic take;
        bus.wr_allow = 1'b0;
        wlog.delete();
        bus.in_valid  = 1'b1;
        bus.in_px     = 16'(-40);
        bus.in_py     = 16'(-12);
        bus.in_colour = 8'h20;
        for (int k = 0; k < 20; k++) begin
            take = (acc < 12) && (bus.in_ready === 1'b1);
            @(negedge clk);
            if (take) begin
                acc++;
                bus.in_px     = 16'(10 * acc - 40);
                bus.in_py     = 16'(3 * acc - 12);
                bus.in_colour = 8'(32'h20 + acc);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc != 8) begin
            errors++;
            $display("FAIL bp_accepted got %0d want 8", acc);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || wlog.size() != 0) begin
            errors++;
            $display("FAIL bp_full got ready=%b writes=%0d want 0/0", bus.in_ready, wlog.size());
        end
        bus.wr_allow = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (wlog.size() != 8) begin
            errors++;
            $display("FAIL bp_drain_count got %0d want 8", wlog.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) begin
                checks++;
                if (wlog[i].addr !== exp_addr(10 * i - 40, 3 * i - 12) ||
                    wlog[i].data !== 8'(32'h20 + i) || wlog[i].cyc != wlog[0].cyc + i) begin
                    errors++;
                    $display("FAIL bp_write%0d got %0d/%0h@%0d want %0d/%0h@%0d", i,
                             wlog[i].addr, wlog[i].data, wlog[i].cyc,
                             exp_addr(10 * i - 40, 3 * i - 12), 8'(32'h20 + i), wlog[0].cyc + i);
                end
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_back got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad = -1;
        bus.wr_allow = 1'b0;
        send(1, 1, 8'hA1);
        send(2, 2, 8'hA2);
        send(3, 3, 8'hA3);
        wlog.delete();
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        checks++;
        if (clear_busy !== 1'b1 || bus.in_ready !== 1'b0 || clip_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_entry got busy=%b ready=%b clip=%0d want 1/0/0",
                     clear_busy, bus.in_ready, clip_count);
        end
        bus.wr_allow = 1'b1;
        for (int k = 0; k < 600 && wlog.size() < 500; k++) @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        for (int k = 0; k < 600 && wlog.size() < 1000; k++) @(negedge clk);
        checks++;
        if (wlog.size() != 1000) begin
            errors++;
            $display("FAIL clear_progress got %0d writes want 1000", wlog.size());
        end
        foreach (wlog[i]) begin
            if (bad < 0 && (wlog[i].addr !== 19'(i) || wlog[i].data !== 8'h00)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL clear_sweep at %0d got %0d/%0h want %0d/00",
                     bad, wlog[bad].addr, wlog[bad].data, bad);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_reset got wr_en=%b busy=%b want 0/0", bus.wr_en, clear_busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wlog.delete();
        @(negedge clk);
        checks++;
        if (clear_busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got busy=%b ready=%b want 0/1", clear_busy, bus.in_ready);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (wlog.size() != 0) begin
            errors++;
            $display("FAIL no_resume got %0d writes want 0", wlog.size());
        end
        send(5, -3, 8'h77);
        repeat (5) @(negedge clk);
        checks++;
        if (wlog.size() != 1 || wlog[0].addr !== 19'd152005 || wlog[0].data !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_point got %0d writes first %0d/%0h want 1 152005/77",
                     wlog.size(), wlog.size() > 0 ? wlog[0].addr : 19'd0,
                     wlog.size() > 0 ? wlog[0].data : 8'd0);
        end
    endtask

    task automatic test_full_clear();
        int bad = -1;
        int k;
        bus_s.wr_allow  = 1'b1;
        bus_s.in_valid  = 1'b1;
        bus_s.in_px     = 16'sd100;
        bus_s.in_py     = 16'sd0;
        bus_s.in_colour = 8'h09;
        @(negedge clk);
        bus_s.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (clip_count_s !== 16'd1) begin
            errors++;
            $display("FAIL small_clip got %0d want 1", clip_count_s);
        end
        bus_s.wr_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_s.in_valid  = 1'b1;
            bus_s.in_px     = 16'(i);
            bus_s.in_py     = 16'(i);
            bus_s.in_colour = 8'(32'hB0 + i);
            @(negedge clk);
        end
        bus_s.in_valid = 1'b0;
        slog.delete();
        clear_start_s = 1'b1;
        @(negedge clk);
        clear_start_s = 1'b0;
        checks++;
        if (clear_busy_s !== 1'b1) begin
            errors++;
            $display("FAIL small_busy got %b want 1", clear_busy_s);
        end
        bus_s.wr_allow = 1'b1;
        for (k = 0; k < 700; k++) begin
            @(negedge clk);
            if (clear_busy_s !== 1'b1) break;
        end
        checks++;
        if (slog.size() != 512) begin
            errors++;
            $display("FAIL small_clear_count got %0d want 512", slog.size());
        end
        foreach (slog[i]) begin
            if (bad < 0 && (slog[i].addr !== 19'(i) || slog[i].data !== 8'h00)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL small_sweep at %0d got %0d/%0h want %0d/00",
                     bad, slog[bad].addr, slog[bad].data, bad);
        end
        checks++;
        if (clear_busy_s !== 1'b0 || slog.size() == 0 || slog[slog.size() - 1].cyc != cyc) begin
            errors++;
            $display("FAIL small_busy_fall got busy=%b at edge %0d want 0 at last write edge",
                     clear_busy_s, cyc);
        end
        checks++;
        if (bus_s.in_ready !== 1'b1 || clip_count_s !== 16'd0) begin
            errors++;
            $display("FAIL small_after got ready=%b clip=%0d want 1/0", bus_s.in_ready, clip_count_s);
        end
    endtask

    initial begin
        reset         = 1'b0;
        reset_s       = 1'b0;
        clear_start   = 1'b0;
        clear_start_s = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_px     = '0;
        bus.in_py     = '0;
        bus.in_colour = '0;
        bus.wr_allow  = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_px     = '0;
        bus_s.in_py     = '0;
        bus_s.in_colour = '0;
        bus_s.wr_allow  = 1'b0;

        test_reset();
        test_single();
        test_clip();
        test_back_pressure();
        test_reset_mid_clear();
        test_full_clear();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_plot_queue.md
PIXEL_PLOT_QUEUE -- requirements
Module: pixel_plot_queue

Interface
REQ-001 SHALL have parameters H_VISIBLE = 640, V_VISIBLE = 480, DEPTH = 8 (power of two, at least 2); DEPTH counts the queue slots plus the address-stage register.
REQ-002 SHALL have port `clk`, input, 1 bit: the only clock; every state change occurs on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-low (0 = reset).
REQ-004 SHALL have ports `in_valid` (input, 1), `in_ready` (output, 1), `in_px` (input, 16, signed), `in_py` (input, 16, signed) and `in_colour` (input, 8): the plot request from the curve generator.
REQ-005 SHALL have ports `wr_allow` (input, 1), `wr_en` (output, 1), `wr_addr` (output, 19) and `wr_data` (output, 8): the frame-buffer write port; `wr_allow` high means the buffer accepts a write on the next edge.
REQ-006 SHALL have ports `clear_start` (input, 1, single-cycle pulse), `clear_busy` (output, 1) and `clip_count` (output, 16).

Function
REQ-007 SHALL transfer a request on a rising edge where in_valid and in_ready are both high.
REQ-008 SHALL drive in_ready from registered state only: high when in RUN and (entries in queue + address-stage occupied) < DEPTH; no combinational path from wr_allow or in_valid.
REQ-009 SHALL clip each transferred request: visible iff -320 <= px <= 319 and -240 <= py <= 239 (general form: -H/2..H/2-1, -V/2..V/2-1).
REQ-010 SHALL discard each clipped request, completing its handshake, and SHALL increment clip_count by 1, saturating at 0xFFFF.
REQ-011 SHALL compute, for a visible point, addr = 153920 + py*640 + px, i.e. (H*V+H)/2 + py*H + px, in the address stage using at least 20-bit signed intermediates, truncated to 19 bits; (-320,-240) -> 0 and (319,239) -> 307199.
REQ-012 SHALL push a visible point into the FIFO one edge after its transfer; the FIFO SHALL hold {addr, colour} in arrival order.
REQ-013 SHALL, in RUN with the FIFO non-empty and wr_allow high, pop the head on that edge and register wr_en=1, wr_addr and wr_data from it; otherwise it SHALL register wr_en=0.
REQ-014 SHALL present wr_en high during the cycle after edge N+2 for a request transferred at edge N, when wr_allow is held high and the FIFO is empty beforehand.
REQ-015 SHALL hold wr_en high for exactly one cycle per write; wr_addr and wr_data are don't-care while wr_en is low.
REQ-016 SHALL allow a push and a pop on the same edge; the FIFO count SHALL then remain unchanged.
REQ-017 SHALL implement states RUN and CLEAR.
REQ-018 SHALL, on clear_start high in RUN, enter CLEAR on that edge: flush the FIFO and address stage (flushed points uncounted, unwritten), reset clip_count to 0, reset the clear pointer to 0 and set clear_busy=1.
REQ-019 SHALL, in CLEAR, hold in_ready=0 and, on each edge with wr_allow high, register wr_en=1, wr_addr=pointer, wr_data=0x00 and increment the pointer.
REQ-020 SHALL, on the edge that issues the write to address 307199, return to RUN with clear_busy=0; in_ready SHALL rise the cycle after.
REQ-021 SHALL ignore clear_start while in CLEAR.
REQ-022 SHALL treat clear_start and a transfer on the same edge as clear winning: the transfer cannot occur, because in_ready is registered and goes low from that edge.

Reset
REQ-023 SHALL, while reset is low, immediately force wr_en=0, wr_addr=0, wr_data=0, clear_busy=0, clip_count=0, an empty FIFO, an empty address stage and state RUN, and hold in_ready=0.
REQ-024 SHALL, on reset assertion mid-clear or mid-drain, abandon the operation; after release it SHALL not resume, and in_ready SHALL be 1 on the first cycle after release.

Verification
REQ-025 SHALL be verified by this scenario: drive reset=0 for 3 cycles then release -> all outputs zero during reset; in_ready=1 and wr_en=0 after release.
REQ-026 SHALL be verified by this scenario: with wr_allow=1, send (0,0,0x5A) at edge N -> wr_en=1, wr_addr=153920, wr_data=0x5A in the cycle after edge N+2, and one write only.
REQ-027 SHALL be verified by this scenario: send (-320,-240,1), (319,239,2), (320,0,3), (0,-241,4) -> writes to 0 (data 1) and 307199 (data 2) only; clip_count=2.
REQ-028 SHALL be verified by this scenario: with wr_allow=0, offer 12 consecutive points -> exactly 8 accepted, then in_ready=0; raise wr_allow -> 8 writes in order on consecutive cycles and in_ready returns to 1.
REQ-029 SHALL be verified by this scenario: queue 3 points with wr_allow=0, pulse clear_start, then set wr_allow=1 -> none of the 3 points is written; exactly 307200 writes of 0x00 to addresses 0..307199 ascending; clear_busy falls after the last write; clip_count=0.
REQ-030 SHALL be verified by this scenario: assert reset when the clear pointer is 1000 -> wr_en=0 immediately; after release clear_busy=0, no further clear writes, and a new point is written normally.
